// File: rtl/ar_credit_ctrl.sv
// ar_credit_ctrl: flow-control scheduler for the AR engine's enable input.
// It admits a new AR burst only when the read-data buffer has room for a
// worst-case burst and the outstanding-transaction limit has not been reached.
// It tracks beats reserved by issued ARs, beats already buffered, and open ARs.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   clear_i            synchronous soft clear (same effect as reset)
//   pause_i            forces enable_o low; counters keep updating
//   ar_fire_i/ar_len_i AR handshake and its arlen
//   r_fire_i/r_last_i  R beat accepted into the buffer and its rlast
//   buf_pop_i          one beat removed from the buffer by the consumer
//   enable_o           AR engine enable
//   inflight_beats_o   beats requested but not yet received
//   buffered_beats_o   beats currently in the buffer
//   outstanding_o      AR transactions without a received rlast
//   idle_o             all counters zero
//   err_o              sticky protocol/overflow error
module ar_credit_ctrl #(
  parameter int unsigned AXI_MAX_ARLEN   = 15,
  parameter int unsigned BUF_DEPTH       = 128,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = $clog2(BUF_DEPTH + 1),
  parameter int unsigned TXN_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear_i,
  input  logic             pause_i,
  input  logic             ar_fire_i,
  input  logic [7:0]       ar_len_i,
  input  logic             r_fire_i,
  input  logic             r_last_i,
  input  logic             buf_pop_i,
  output logic             enable_o,
  output logic [CNT_W-1:0] inflight_beats_o,
  output logic [CNT_W-1:0] buffered_beats_o,
  output logic [TXN_W-1:0] outstanding_o,
  output logic             idle_o,
  output logic             err_o
);

  localparam int unsigned MaxBurst     = AXI_MAX_ARLEN + 1;
  // Largest reservation that still leaves room for one worst-case burst.
  localparam int unsigned ReserveLimit = BUF_DEPTH - MaxBurst;

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] buffered_q, buffered_d;
  logic [TXN_W-1:0] outstanding_q, outstanding_d;
  logic             err_q, err_d;

  logic [CNT_W:0]   reserved;
  logic [CNT_W:0]   burst_beats;
  logic [CNT_W:0]   inflight_sum;
  logic [CNT_W:0]   buffered_sum;
  logic [TXN_W:0]   outstanding_sum;
  logic             infl_uflow, buf_uflow, out_uflow;
  logic             infl_dec, buf_dec, out_dec;
  logic             len_bad, fire_bad, overflow;

  // Depends on registered state and pause only, never on the fire strobes.
  assign reserved = {1'b0, inflight_q} + {1'b0, buffered_q};
  assign enable_o = !pause_i
                    && (reserved <= (CNT_W + 1)'(ReserveLimit))
                    && (outstanding_q < TXN_W'(MAX_OUTSTANDING));

  always_comb begin
    burst_beats = '0;
    if (ar_fire_i) begin
      burst_beats = (CNT_W + 1)'(ar_len_i) + (CNT_W + 1)'(1);
    end

    // A decrement on an empty counter is an error unless a same-cycle
    // increment covers it; the suppressed decrement saturates at zero.
    infl_uflow = r_fire_i && (inflight_q == '0) && !ar_fire_i;
    buf_uflow  = buf_pop_i && (buffered_q == '0) && !r_fire_i;
    out_uflow  = r_fire_i && r_last_i && (outstanding_q == '0) && !ar_fire_i;
    infl_dec   = r_fire_i && !infl_uflow;
    buf_dec    = buf_pop_i && !buf_uflow;
    out_dec    = r_fire_i && r_last_i && !out_uflow;

    inflight_sum    = {1'b0, inflight_q} + burst_beats - (CNT_W + 1)'(infl_dec);
    buffered_sum    = {1'b0, buffered_q} + (CNT_W + 1)'(r_fire_i) - (CNT_W + 1)'(buf_dec);
    outstanding_sum = {1'b0, outstanding_q} + (TXN_W + 1)'(ar_fire_i)
                      - (TXN_W + 1)'(out_dec);

    inflight_d    = inflight_sum[CNT_W-1:0];
    buffered_d    = buffered_sum[CNT_W-1:0];
    outstanding_d = outstanding_sum[TXN_W-1:0];

    // Carry out of the widened sums means the counter wrapped.
    overflow = inflight_sum[CNT_W] || buffered_sum[CNT_W] || outstanding_sum[TXN_W];
    len_bad  = 32'(ar_len_i) > AXI_MAX_ARLEN;
    // An unpermitted fire is still counted above; it only raises err.
    fire_bad = ar_fire_i && (!enable_o || len_bad);

    err_d = err_q || infl_uflow || buf_uflow || out_uflow || fire_bad || overflow;
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear_i) begin
      inflight_q    <= '0;
      buffered_q    <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      inflight_q    <= inflight_d;
      buffered_q    <= buffered_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign inflight_beats_o = inflight_q;
  assign buffered_beats_o = buffered_q;
  assign outstanding_o    = outstanding_q;
  assign err_o            = err_q;
  assign idle_o           = (inflight_q == '0) && (buffered_q == '0) && (outstanding_q == '0);

endmodule

// File: tb/tb_ar_credit_ctrl.sv
// Testbench for ar_credit_ctrl: directed scenarios against hand-derived values,
// plus a randomized run checked against a behavioural credit model.
module tb_ar_credit_ctrl;

  localparam int MaxLen = 15;
  localparam int Depth  = 128;
  localparam int MaxOut = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clear = 1'b0;
  logic       pause = 1'b0;
  logic       ar_fire = 1'b0;
  logic [7:0] ar_len = 8'd0;
  logic       r_fire = 1'b0;
  logic       r_last = 1'b0;
  logic       buf_pop = 1'b0;
  logic       enable, idle, err;
  logic [7:0] inflight, buffered;
  logic [2:0] outstanding;

  // Behavioural model: plain integer counters that clamp at zero on underflow.
  int m_infl = 0;
  int m_buf  = 0;
  int m_out  = 0;
  bit m_err  = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ar_credit_ctrl #(
    .AXI_MAX_ARLEN  (MaxLen),
    .BUF_DEPTH      (Depth),
    .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .clear_i         (clear),
    .pause_i         (pause),
    .ar_fire_i       (ar_fire),
    .ar_len_i        (ar_len),
    .r_fire_i        (r_fire),
    .r_last_i        (r_last),
    .buf_pop_i       (buf_pop),
    .enable_o        (enable),
    .inflight_beats_o(inflight),
    .buffered_beats_o(buffered),
    .outstanding_o   (outstanding),
    .idle_o          (idle),
    .err_o           (err)
  );

  function automatic bit model_en();
    return !pause && ((Depth - (m_infl + m_buf)) >= MaxLen + 1) && (m_out < MaxOut);
  endfunction

  // Advance one clock with the currently driven inputs, updating the model
  // from the pre-edge state; strobes are dropped afterwards.
  task automatic tick();
    int  infl_n, buf_n, out_n;
    bit  err_n;
    bit  en;
    en = model_en();
    if (!rstn || clear) begin
      infl_n = 0; buf_n = 0; out_n = 0; err_n = 1'b0;
    end else begin
      err_n  = m_err;
      infl_n = m_infl + (ar_fire ? int'(ar_len) + 1 : 0) - (r_fire ? 1 : 0);
      buf_n  = m_buf + (r_fire ? 1 : 0) - (buf_pop ? 1 : 0);
      out_n  = m_out + (ar_fire ? 1 : 0) - ((r_fire && r_last) ? 1 : 0);
      if (infl_n < 0) begin infl_n = 0; err_n = 1'b1; end
      if (buf_n < 0)  begin buf_n = 0;  err_n = 1'b1; end
      if (out_n < 0)  begin out_n = 0;  err_n = 1'b1; end
      if (ar_fire && (!en || int'(ar_len) > MaxLen)) err_n = 1'b1;
    end
    @(posedge clk);
    #1;
    m_infl = infl_n; m_buf = buf_n; m_out = out_n; m_err = err_n;
    ar_fire = 1'b0; r_fire = 1'b0; r_last = 1'b0; buf_pop = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({inflight, buffered, outstanding, err, idle, enable} !== {8'd0, 8'd0, 3'd0, 3'b011}) begin
      n_fail++;
      $display("FAIL reset: got infl=%0d buf=%0d out=%0d err=%b idle=%b en=%b, want 0 0 0 0 1 1",
               inflight, buffered, outstanding, err, idle, enable);
    end
    tick();
    n_cmp++;
    if ({idle, enable, err} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_idle_cycle: got idle=%b en=%b err=%b, want 1 1 0", idle, enable, err);
    end
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (enable !== 1'b1) begin
        n_fail++;
        $display("FAIL outst_en_before_%0d: got %b want 1", i, enable);
      end
      ar_fire = 1'b1; ar_len = 8'd15;
      tick();
    end
    n_cmp++;
    if ({inflight, outstanding, enable, err} !== {8'd64, 3'd4, 2'b00}) begin
      n_fail++;
      $display("FAIL outst_limit: got infl=%0d out=%0d en=%b err=%b, want 64 4 0 0",
               inflight, outstanding, enable, err);
    end
  endtask

  task automatic test_buffer_credit();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      ar_fire = 1'b1; ar_len = 8'd15;
      tick();
      for (int j = 0; j < 16; j++) begin
        r_fire = 1'b1; r_last = (j == 15);
        tick();
      end
    end
    n_cmp++;
    if ({inflight, buffered, outstanding, enable} !== {8'd0, 8'd112, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL credit_112: got infl=%0d buf=%0d out=%0d en=%b, want 0 112 0 1",
               inflight, buffered, outstanding, enable);
    end
    ar_fire = 1'b1; ar_len = 8'd15;
    tick();
    n_cmp++;
    if ({inflight, buffered, outstanding, enable, err} !== {8'd16, 8'd112, 3'd1, 2'b00}) begin
      n_fail++;
      $display("FAIL credit_full: got infl=%0d buf=%0d out=%0d en=%b err=%b, want 16 112 1 0 0",
               inflight, buffered, outstanding, enable, err);
    end
    for (int i = 0; i < 15; i++) begin
      buf_pop = 1'b1;
      tick();
    end
    n_cmp++;
    if ({buffered, enable} !== {8'd97, 1'b0}) begin
      n_fail++;
      $display("FAIL credit_pop15: got buf=%0d en=%b, want 97 0", buffered, enable);
    end
    buf_pop = 1'b1;
    tick();
    n_cmp++;
    if ({buffered, enable} !== {8'd96, 1'b1}) begin
      n_fail++;
      $display("FAIL credit_pop16: got buf=%0d en=%b, want 96 1", buffered, enable);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ar_fire = 1'b1; ar_len = 8'd5;
    tick();
    for (int i = 0; i < 5; i++) begin
      r_fire = 1'b1;
      tick();
    end
    n_cmp++;
    if ({inflight, buffered, outstanding} !== {8'd1, 8'd5, 3'd1}) begin
      n_fail++;
      $display("FAIL simul_setup: got infl=%0d buf=%0d out=%0d, want 1 5 1",
               inflight, buffered, outstanding);
    end
    ar_fire = 1'b1; ar_len = 8'd3; r_fire = 1'b1; r_last = 1'b1; buf_pop = 1'b1;
    tick();
    n_cmp++;
    if ({inflight, buffered, outstanding, err} !== {8'd4, 8'd5, 3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_all: got infl=%0d buf=%0d out=%0d err=%b, want 4 5 1 0",
               inflight, buffered, outstanding, err);
    end
    // Every decrement on a zero counter is covered by a same-cycle increment.
    do_reset();
    ar_fire = 1'b1; ar_len = 8'd0; r_fire = 1'b1; r_last = 1'b1; buf_pop = 1'b1;
    tick();
    n_cmp++;
    if ({inflight, buffered, outstanding, err, idle} !== {8'd0, 8'd0, 3'd0, 2'b01}) begin
      n_fail++;
      $display("FAIL simul_from_zero: got infl=%0d buf=%0d out=%0d err=%b idle=%b, want 0 0 0 0 1",
               inflight, buffered, outstanding, err, idle);
    end
  endtask

  task automatic test_errors();
    do_reset();
    r_fire = 1'b1;
    tick();
    n_cmp++;
    if ({err, inflight} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL err_r_empty: got err=%b infl=%0d, want 1 0", err, inflight);
    end
    repeat (10) tick();
    n_cmp++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    clear = 1'b1;
    tick();
    n_cmp++;
    if ({err, idle, enable} !== 3'b011) begin
      n_fail++;
      $display("FAIL err_clear: got err=%b idle=%b en=%b, want 0 1 1", err, idle, enable);
    end
    // Pop from an empty buffer.
    buf_pop = 1'b1;
    tick();
    n_cmp++;
    if ({err, buffered} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL err_pop_empty: got err=%b buf=%0d, want 1 0", err, buffered);
    end
    // rlast with no open transaction while beats are still in flight.
    clear = 1'b1; tick();
    ar_fire = 1'b1; ar_len = 8'd1; tick();
    r_fire = 1'b1; r_last = 1'b1; tick();
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_rlast_legal: got err=%b want 0", err);
    end
    r_fire = 1'b1; r_last = 1'b1; tick();
    n_cmp++;
    if ({err, outstanding, inflight} !== {1'b1, 3'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL err_rlast_none: got err=%b out=%0d infl=%0d, want 1 0 0",
               err, outstanding, inflight);
    end
    // Oversized arlen is counted and flagged.
    clear = 1'b1; tick();
    ar_fire = 1'b1; ar_len = 8'd16; tick();
    n_cmp++;
    if ({err, inflight, outstanding} !== {1'b1, 8'd17, 3'd1}) begin
      n_fail++;
      $display("FAIL err_len: got err=%b infl=%0d out=%0d, want 1 17 1", err, inflight, outstanding);
    end
    // Fire while paused is counted and flagged.
    clear = 1'b1; tick();
    pause = 1'b1;
    ar_fire = 1'b1; ar_len = 8'd0; tick();
    pause = 1'b0;
    n_cmp++;
    if ({err, inflight, outstanding} !== {1'b1, 8'd1, 3'd1}) begin
      n_fail++;
      $display("FAIL err_fire_disabled: got err=%b infl=%0d out=%0d, want 1 1 1",
               err, inflight, outstanding);
    end
    // Clear wins over a same-cycle fire.
    clear = 1'b1; ar_fire = 1'b1; ar_len = 8'd7; tick();
    n_cmp++;
    if ({inflight, outstanding, err, idle} !== {8'd0, 3'd0, 2'b01}) begin
      n_fail++;
      $display("FAIL clear_priority: got infl=%0d out=%0d err=%b idle=%b, want 0 0 0 1",
               inflight, outstanding, err, idle);
    end
  endtask

  task automatic test_pause_reset();
    do_reset();
    pause = 1'b1;
    #1;
    n_cmp++;
    if ({enable, idle} !== 2'b01) begin
      n_fail++;
      $display("FAIL pause_on: got en=%b idle=%b, want 0 1", enable, idle);
    end
    pause = 1'b0;
    #1;
    n_cmp++;
    if (enable !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_release: got en=%b want 1", enable);
    end
    for (int i = 0; i < 3; i++) begin
      ar_fire = 1'b1; ar_len = 8'd15; tick();
    end
    repeat (8) begin
      r_fire = 1'b1; tick();
    end
    n_cmp++;
    if ({inflight, buffered, outstanding} !== {8'd40, 8'd8, 3'd3}) begin
      n_fail++;
      $display("FAIL midtraffic: got infl=%0d buf=%0d out=%0d, want 40 8 3",
               inflight, buffered, outstanding);
    end
    rstn = 1'b0; ar_fire = 1'b1; ar_len = 8'd15; r_fire = 1'b1;
    tick();
    rstn = 1'b1;
    n_cmp++;
    if ({inflight, buffered, outstanding, err, idle} !== {8'd0, 8'd0, 3'd0, 2'b01}) begin
      n_fail++;
      $display("FAIL reset_midtraffic: got infl=%0d buf=%0d out=%0d err=%b idle=%b, want 0 0 0 0 1",
               inflight, buffered, outstanding, err, idle);
    end
  endtask

  task automatic test_random();
    bit exp_idle;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      pause = ($urandom_range(0, 7) == 0);
      if ((model_en() && $urandom_range(0, 2) == 0) || $urandom_range(0, 99) == 0) begin
        ar_fire = 1'b1;
        ar_len  = ($urandom_range(0, 39) == 0) ? 8'($urandom_range(16, 20))
                                               : 8'($urandom_range(0, 15));
      end
      r_fire  = (m_infl > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
      r_last  = r_fire && ($urandom_range(0, 3) == 0);
      buf_pop = (m_buf > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
      clear   = ($urandom_range(0, 63) == 0);
      tick();
      exp_idle = (m_infl == 0) && (m_buf == 0) && (m_out == 0);
      n_cmp++;
      if ({inflight, buffered, outstanding, err, idle, enable} !==
          {8'(m_infl), 8'(m_buf), 3'(m_out), m_err, exp_idle, model_en()}) begin
        n_fail++;
        $display("FAIL random_c%0d: got infl=%0d buf=%0d out=%0d err=%b idle=%b en=%b, want %0d %0d %0d %b %b %b",
                 c, inflight, buffered, outstanding, err, idle, enable,
                 m_infl, m_buf, m_out, m_err, exp_idle, model_en());
      end
    end
    pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_outstanding_limit();
    test_buffer_credit();
    test_simultaneous();
    test_errors();
    test_pause_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
